toggle_req_gen: RTL

//   Upstream request generator for the toggle flip-flop stage. Turns a raw,

---
 rtl/toggle_req_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/toggle_req_gen.sv
// ---------------------------------------------------------------------------
// toggle_req_gen
//   Turns a raw, bouncing push-button level into clean single-cycle toggle
//   requests for the downstream toggle stage, with optional auto-repeat while
//   the button is held.
//
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous, active-low reset
//   btn_raw      in   1       raw button level, asynchronous to clk
//   repeat_en    in   1       1 = auto-repeat while held (synchronous)
//   en_pulse     out  1       registered one-cycle toggle request
//   btn_stable   out  1       debounced button level
//   pulse_count  out  PCNT_W  en_pulse cycles issued, wraps silently
// ---------------------------------------------------------------------------
module toggle_req_gen #(
  parameter int DEB_CYCLES    = 16,
  parameter int DEB_W         = 5,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 20,
  parameter int RPT_W         = 8,
  parameter int PCNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic              repeat_en,
  output logic              en_pulse,
  output logic              btn_stable,
  output logic [PCNT_W-1:0] pulse_count
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;

  // Parameter sanity checks, evaluated at elaboration.
  if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_cycles
    $error("toggle_req_gen: cycle parameters must be >= 1");
  end
  if ((2 ** DEB_W) <= (DEB_CYCLES - 1)) begin : g_chk_deb_w
    $error("toggle_req_gen: DEB_W too small for DEB_CYCLES");
  end
  if ((2 ** RPT_W) <= (RPT_MAX - 1)) begin : g_chk_rpt_w
    $error("toggle_req_gen: RPT_W too small for repeat timing");
  end
  if (PCNT_W < 1) begin : g_chk_pcnt_w
    $error("toggle_req_gen: PCNT_W must be >= 1");
  end

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;   // btn_s
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              btn_stable_q, btn_stable_d;
  state_t            state_q, state_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              en_pulse_q, en_pulse_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    // Two-flop synchroniser for the asynchronous button level.
    sync1_d = btn_raw;
    sync2_d = sync1_q;

    // Debounce: btn_s must disagree with btn_stable for DEB_CYCLES
    // consecutive cycles; any agreement in between restarts the count.
    btn_stable_d = btn_stable_q;
    deb_cnt_d    = deb_cnt_q;
    if (sync2_q == btn_stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      btn_stable_d = sync2_q;
      deb_cnt_d    = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    // Request FSM. Release is tested first so it wins over a due repeat,
    // and dropping repeat_en is tested before the due check for the same
    // reason.
    en_pulse_d = 1'b0;
    state_d    = state_q;
    rpt_cnt_d  = rpt_cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_stable_q) begin
          en_pulse_d = 1'b1;
          rpt_cnt_d  = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!btn_stable_q) begin
          state_d = IDLE;
        end else if (!repeat_en) begin
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == DELAY_LAST) begin
          en_pulse_d = 1'b1;
          rpt_cnt_d  = '0;
          state_d    = REPEAT;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_stable_q) begin
          state_d = IDLE;
        end else if (!repeat_en) begin
          rpt_cnt_d = '0;
          state_d   = HOLD;
        end else if (rpt_cnt_q == PER_LAST) begin
          en_pulse_d = 1'b1;
          rpt_cnt_d  = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase

    // Counted on the same edge that raises en_pulse; wraps naturally.
    pcnt_d = en_pulse_d ? (pcnt_q + 1'b1) : pcnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_cnt_q    <= '0;
      btn_stable_q <= 1'b0;
      state_q      <= IDLE;
      rpt_cnt_q    <= '0;
      en_pulse_q   <= 1'b0;
      pcnt_q       <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_cnt_q    <= deb_cnt_d;
      btn_stable_q <= btn_stable_d;
      state_q      <= state_d;
      rpt_cnt_q    <= rpt_cnt_d;
      en_pulse_q   <= en_pulse_d;
      pcnt_q       <= pcnt_d;
    end
  end

  assign en_pulse    = en_pulse_q;
  assign btn_stable  = btn_stable_q;
  assign pulse_count = pcnt_q;

endmodule
